niosqs_nios2_qsys_0_cpu_debug_mem_master: RTL and testbench
===========================================================

# niosqs_nios2_qsys_0_cpu_debug_mem_master

Downstream consumer of the CPU debug-slave wrapper's system-clock outputs (`jdo`, `take_action_ocimem_*`). It decodes JTAG monitor-memory commands into reads and writes on a simple waitrequest/readdatavalid memory port. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug slave for shift-out. It owns the monitor address register, auto-increment and a bus-timeout watchdog.

## Interface
Parameters
- `ADDR_W`, default 10: word-address width, legal range 1..16. Address field is `jdo[17+ADDR_W-1:17]`.
- `WAIT_TIMEOUT`, default 255: maximum cycles a transaction may stay outstanding before it is aborted. Must be ≥ 1.

Ports
- `clk` in 1: sole clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `jdo` in 38: command payload from the debug slave.
- `take_action_ocimem_a` in 1: load-address strobe; one cycle wide.
- `take_no_action_ocimem_a` in 1: read-next strobe.
- `take_action_ocimem_b` in 1: write strobe; data is `jdo[34:3]`.
- `MonDReg` out 32: last read data.
- `MonAReg` out ADDR_W: current word address.
- `monitor_ready` out 1: registered; high when idle.
- `monitor_error` out 1: sticky error flag.
- `mem_addr` out ADDR_W: memory word address.
- `mem_wdata` out 32: write data.
- `mem_rd` out 1: read request.
- `mem_wr` out 1: write request.
- `mem_waitrequest` in 1: memory stall.
- `mem_rdata` in 32: read data.
- `mem_rdvalid` in 1: read data valid.

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- Commands are accepted only in IDLE. When several strobes are high in one cycle, the priority is ocimem_b > ocimem_a > no_action_a; lower-priority strobes are dropped silently.
- `take_action_ocimem_a`:
  - `MonAReg` ← address field.
  - Clear `monitor_error`.
  - If `jdo[34]` = 1, go to RD_REQ at the new address; otherwise stay in IDLE.
- `take_no_action_ocimem_a`: `MonAReg` ← `MonAReg`+1, wrapping mod 2^ADDR_W; go to RD_REQ at the incremented address.
- `take_action_ocimem_b`: latch `jdo[34:3]` into `mem_wdata`; go to WR_REQ at the current `MonAReg`.
- RD_REQ:
  - `mem_rd`=1 and `mem_addr`=`MonAReg`, held stable while `mem_waitrequest`=1.
  - First cycle with `mem_waitrequest`=0 → RD_WAIT, `mem_rd`=0.
- RD_WAIT: on `mem_rdvalid`=1, `MonDReg` ← `mem_rdata`, go to IDLE. `mem_rdvalid` outside RD_WAIT is ignored.
- WR_REQ:
  - `mem_wr`=1, held stable while `mem_waitrequest`=1.
  - On acceptance: go to IDLE and `MonAReg` ← `MonAReg`+1, wrapping.
- Any strobe arriving outside IDLE is ignored and sets `monitor_error`.
- Watchdog:
  - The counter clears on entry to RD_REQ or WR_REQ and increments every non-IDLE cycle.
  - When the count reaches WAIT_TIMEOUT: drop `mem_rd`/`mem_wr`, go to IDLE, set `monitor_error`.
  - On abort, `MonDReg` and `MonAReg` are unchanged; no increment on an aborted write.
- Reset values: `MonDReg`=0, `MonAReg`=0, `monitor_ready`=1, `monitor_error`=0, `mem_rd`=0, `mem_wr`=0, `mem_wdata`=0, state=IDLE, watchdog=0.
- Reset asserted mid-transaction abandons the transaction immediately at the next clock edge. Outputs take their reset values.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Strobe in cycle N → `mem_rd`/`mem_wr` high and `monitor_ready`=0 in cycle N+1.
- Write with no stall: `mem_wr` high in N+1 only; `monitor_ready`=1 and `MonAReg`+1 in N+2.
- Read:
  - With no stall, `mem_rd` high in N+1 only.
  - If `mem_rdvalid` arrives in cycle M, `MonDReg` updates and `monitor_ready`=1 in M+1.
  - Earliest M is N+2 (rdvalid latency ≥ 1).
- Each stall cycle adds exactly one cycle.
- Timeout: `monitor_error`=1 and `monitor_ready`=1 exactly WAIT_TIMEOUT+1 cycles after the strobe.
- A new command is accepted in the same cycle `monitor_ready` reads 1.

## Test plan
- Load + read: ocimem_a with address 0x005 and `jdo[34]`=1, memory returns 0x12345678 with latency 2.
  - Expect `mem_rd` pulse at addr 5.
  - `MonDReg`=0x12345678 and `monitor_ready`=1 at N+4.
  - `MonAReg`=5.
- Write stream: three ocimem_b strobes carrying 0xA, 0xB, 0xC starting from address 0x3FE.
  - Writes land at 0x3FE, 0x3FF, 0x000 (wrap).
  - Final `MonAReg`=0x001.
- Read-next with stall: `MonAReg`=7, no_action_a, `mem_waitrequest` high for 3 cycles.
  - `mem_rd` high for 4 cycles at addr 8.
  - Data is captured.
  - `monitor_error`=0.
- Busy collision: ocimem_b issued during RD_WAIT, plus ocimem_a and no_action_a strobed in the same idle cycle.
  - The write is ignored and `monitor_error`=1.
  - In the simultaneous-strobe case only ocimem_a takes effect.
  - A subsequent ocimem_a clears the error.
- Timeout: WAIT_TIMEOUT=4, `mem_waitrequest` stuck high on a write.
  - `mem_wr` drops.
  - `monitor_error`=1 at N+5.
  - `MonAReg` is unchanged.
- Reset mid-read: `reset_n` low during RD_REQ.
  - Next edge gives `mem_rd`=0, `MonAReg`=0, `MonDReg`=0, `monitor_ready`=1.
  - A late `mem_rdvalid` is ignored.

Source files
------------

// File: rtl/niosqs_nios2_qsys_0_cpu_debug_mem_master.sv
// JTAG monitor-memory master: turns debug-slave ocimem commands into single
// reads/writes on a waitrequest/readdatavalid port, with auto-increment and a bus watchdog.
module niosqs_nios2_qsys_0_cpu_debug_mem_master #(
    parameter int ADDR_W       = 10,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rdvalid
);

    localparam int WD_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WD_W:0] WD_LIMIT = (WD_W + 1)'(WAIT_TIMEOUT);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] mon_a_nxt;
    logic [31:0]       mon_d_nxt;
    logic [31:0]       wdata_nxt;
    logic              err_nxt;
    logic [WD_W-1:0]   wd_cnt, wd_nxt;
    logic [WD_W:0]     wd_inc;
    logic              timeout;
    logic              any_strobe;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            MonAReg       <= '0;
            MonDReg       <= '0;
            mem_wdata     <= '0;
            monitor_error <= 1'b0;
            wd_cnt        <= '0;
        end else begin
            state         <= state_nxt;
            MonAReg       <= mon_a_nxt;
            MonDReg       <= mon_d_nxt;
            mem_wdata     <= wdata_nxt;
            monitor_error <= err_nxt;
            wd_cnt        <= wd_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mon_a_nxt  = MonAReg;
        mon_d_nxt  = MonDReg;
        wdata_nxt  = mem_wdata;
        err_nxt    = monitor_error;
        wd_nxt     = wd_cnt;
        any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
        wd_inc     = {1'b0, wd_cnt} + (WD_W + 1)'(1);
        // A completing handshake wins over a timeout landing on the same cycle.
        timeout    = (wd_inc >= WD_LIMIT);

        if (state != IDLE) begin
            wd_nxt = wd_inc[WD_W-1:0];
            if (any_strobe) err_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (take_action_ocimem_b) begin
                    wdata_nxt = jdo[34:3];
                    state_nxt = WR_REQ;
                    wd_nxt    = '0;
                end else if (take_action_ocimem_a) begin
                    mon_a_nxt = jdo[17 +: ADDR_W];
                    err_nxt   = 1'b0;
                    if (jdo[34]) begin
                        state_nxt = RD_REQ;
                        wd_nxt    = '0;
                    end
                end else if (take_no_action_ocimem_a) begin
                    mon_a_nxt = MonAReg + ADDR_W'(1);
                    state_nxt = RD_REQ;
                    wd_nxt    = '0;
                end
            end
            RD_REQ: begin
                if (!mem_waitrequest) begin
                    state_nxt = RD_WAIT;
                end else if (timeout) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            RD_WAIT: begin
                if (mem_rdvalid) begin
                    mon_d_nxt = mem_rdata;
                    state_nxt = IDLE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            WR_REQ: begin
                if (!mem_waitrequest) begin
                    mon_a_nxt = MonAReg + ADDR_W'(1);
                    state_nxt = IDLE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus-facing outputs decode straight from flops, so no input reaches them combinationally.
    assign monitor_ready = (state == IDLE);
    assign mem_rd        = (state == RD_REQ);
    assign mem_wr        = (state == WR_REQ);
    assign mem_addr      = MonAReg;

endmodule

// File: tb/tb_niosqs_nios2_qsys_0_cpu_debug_mem_master.sv
// Bench for the debug memory master: directed vector table, random transactions
// against a transaction-level memory/register model, and timeout/reset sequences.
module tb_niosqs_nios2_qsys_0_cpu_debug_mem_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        a_s, na_s, b_s;
    logic        waitreq, rdvalid;
    logic [31:0] rdata;

    logic [31:0] mon_d, mwdata, t_mon_d, t_mwdata;
    logic [9:0]  mon_a, maddr, t_mon_a, t_maddr;
    logic        ready, err, mrd, mwr, t_ready, t_err, t_mrd, t_mwr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    niosqs_nios2_qsys_0_cpu_debug_mem_master #(.ADDR_W(10), .WAIT_TIMEOUT(255)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(a_s), .take_no_action_ocimem_a(na_s), .take_action_ocimem_b(b_s),
        .MonDReg(mon_d), .MonAReg(mon_a), .monitor_ready(ready), .monitor_error(err),
        .mem_addr(maddr), .mem_wdata(mwdata), .mem_rd(mrd), .mem_wr(mwr),
        .mem_waitrequest(waitreq), .mem_rdata(rdata), .mem_rdvalid(rdvalid));

    niosqs_nios2_qsys_0_cpu_debug_mem_master #(.ADDR_W(10), .WAIT_TIMEOUT(4)) dut_t (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(a_s), .take_no_action_ocimem_a(na_s), .take_action_ocimem_b(b_s),
        .MonDReg(t_mon_d), .MonAReg(t_mon_a), .monitor_ready(t_ready), .monitor_error(t_err),
        .mem_addr(t_maddr), .mem_wdata(t_mwdata), .mem_rd(t_mrd), .mem_wr(t_mwr),
        .mem_waitrequest(waitreq), .mem_rdata(rdata), .mem_rdvalid(rdvalid));

    // kind: 0 load addr, 1 load addr + read, 2 read-next, 3 write,
    //       4 load addr + read-next together, 5 all three strobes together
    typedef struct {
        int          kind;
        logic [9:0]  addr;
        logic [31:0] data;
        int          s;
        int          lat;
        bit          coll;
        logic [9:0]  exp_a;
        logic [31:0] exp_d;
        bit          exp_err;
        int          exp_cyc;
        int          exp_pul;
        logic [9:0]  exp_bus;
    } vec_t;

    vec_t        vt[10];
    logic [31:0] ref_mem[1024];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        a_s = 0; na_s = 0; b_s = 0; waitreq = 0; rdvalid = 0; rdata = '0;
    endtask

    // Issues one command, then acts as the memory: stalls s cycles, returns read
    // data lat cycles after acceptance, optionally fires a colliding write strobe.
    task automatic run_txn(input int kind, input logic [9:0] addr, input logic [31:0] data,
                           input int s, input int lat, input bit coll,
                           output int cyc, output int pul,
                           output logic [9:0] bus_a, output logic [31:0] bus_d);
        bit rd_k, wr_k;
        int ck;
        rd_k = (kind == 1) || (kind == 2);
        wr_k = (kind == 3) || (kind == 5);
        ck   = rd_k ? s + 2 : 1;
        jdo  = {6'($urandom), 32'($urandom)};
        if (wr_k) jdo[34:3] = data;
        else begin
            jdo[17 +: 10] = addr;
            jdo[34]       = (kind == 1);
        end
        a_s  = (kind == 0) || (kind == 1) || (kind == 4) || (kind == 5);
        na_s = (kind == 2) || (kind == 4) || (kind == 5);
        b_s  = wr_k;
        cyc = -1; pul = 0; bus_a = 'x; bus_d = 'x;
        step();
        for (int k = 1; k <= 40; k++) begin
            a_s = 0; na_s = 0; b_s = 0; waitreq = 0; rdvalid = 0; rdata = $urandom;
            if (mrd || mwr) begin
                if (pul == 0) begin
                    bus_a = maddr;
                    bus_d = mwdata;
                end
                if (maddr === bus_a) pul++;
            end
            if (ready) begin
                cyc = k;
                break;
            end
            if ((rd_k || wr_k) && k <= s) waitreq = 1;
            if (k == 1 && s >= 1) rdvalid = 1;
            if (rd_k && k == s + 1 + lat) begin
                rdvalid = 1;
                rdata   = data;
            end
            if (coll && k == ck) begin
                b_s = 1;
                jdo = {6'($urandom), 32'($urandom)};
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        int          cyc, pul, k_wr;
        logic [9:0]  bus_a;
        logic [31:0] bus_d;
        logic [9:0]  ref_a;
        logic [31:0] ref_d;
        bit          ref_err;

        vt[0] = '{1, 10'h005, 32'h12345678, 0, 2, 0, 10'h005, 32'h12345678, 0, 4, 1, 10'h005};
        vt[1] = '{0, 10'h3FE, 32'h0,        0, 1, 0, 10'h3FE, 32'h12345678, 0, 1, 0, 10'h000};
        vt[2] = '{3, 10'h000, 32'h0000000A, 0, 1, 0, 10'h3FF, 32'h12345678, 0, 2, 1, 10'h3FE};
        vt[3] = '{3, 10'h000, 32'h0000000B, 0, 1, 0, 10'h000, 32'h12345678, 0, 2, 1, 10'h3FF};
        vt[4] = '{3, 10'h000, 32'h0000000C, 1, 1, 0, 10'h001, 32'h12345678, 0, 3, 2, 10'h000};
        vt[5] = '{0, 10'h007, 32'h0,        0, 1, 0, 10'h007, 32'h12345678, 0, 1, 0, 10'h000};
        vt[6] = '{2, 10'h000, 32'hCAFEF00D, 3, 1, 0, 10'h008, 32'hCAFEF00D, 0, 6, 4, 10'h008};
        vt[7] = '{2, 10'h000, 32'h0BADBEEF, 0, 3, 1, 10'h009, 32'h0BADBEEF, 1, 5, 1, 10'h009};
        vt[8] = '{4, 10'h020, 32'h0,        0, 1, 0, 10'h020, 32'h0BADBEEF, 0, 1, 0, 10'h000};
        vt[9] = '{5, 10'h000, 32'h00012345, 0, 1, 0, 10'h021, 32'h0BADBEEF, 0, 2, 1, 10'h020};

        reset_n = 0;
        jdo = '0;
        clear_inputs();
        step();
        step();
        check("reset_ready", ready, 1);
        check("reset_err", err, 0);
        check("reset_rdwr", {mrd, mwr}, 0);
        check("reset_mona", mon_a, 0);
        check("reset_mond", mon_d, 0);
        check("reset_wdata", mwdata, 0);
        reset_n = 1;
        step();

        for (int i = 0; i < 10; i++) begin
            run_txn(vt[i].kind, vt[i].addr, vt[i].data, vt[i].s, vt[i].lat, vt[i].coll,
                    cyc, pul, bus_a, bus_d);
            check($sformatf("vec%0d_mona", i), mon_a, vt[i].exp_a);
            check($sformatf("vec%0d_mond", i), mon_d, vt[i].exp_d);
            check($sformatf("vec%0d_err", i), err, vt[i].exp_err);
            check($sformatf("vec%0d_cycles", i), cyc, vt[i].exp_cyc);
            check($sformatf("vec%0d_pulses", i), pul, vt[i].exp_pul);
            if (vt[i].exp_pul > 0) check($sformatf("vec%0d_busaddr", i), bus_a, vt[i].exp_bus);
            if (vt[i].kind == 3 || vt[i].kind == 5) check($sformatf("vec%0d_wdata", i), bus_d, vt[i].data);
        end

        // Random transactions against a register/memory-level model
        ref_a = 10'h021; ref_d = 32'h0BADBEEF; ref_err = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        for (int i = 0; i < 150; i++) begin
            int          kind, s, lat, exp_cyc, exp_pul;
            bit          coll;
            logic [9:0]  addr, tgt;
            logic [31:0] data;
            kind = $urandom_range(0, 3);
            addr = 10'($urandom);
            s    = $urandom_range(0, 3);
            lat  = $urandom_range(1, 3);
            coll = (kind != 0) && ($urandom_range(0, 7) == 0);
            data = $urandom;
            exp_cyc = 1; exp_pul = 0; tgt = ref_a;
            case (kind)
                0: begin ref_a = addr; ref_err = 0; end
                1, 2: begin
                    if (kind == 1) begin
                        ref_a = addr; ref_err = 0;
                    end else ref_a = (ref_a + 1) % 1024;
                    tgt = ref_a;
                    data = ref_mem[tgt];
                    ref_d = data;
                    exp_cyc = s + 2 + lat; exp_pul = s + 1;
                end
                default: begin
                    tgt = ref_a;
                    ref_mem[tgt] = data;
                    ref_a = (ref_a + 1) % 1024;
                    exp_cyc = s + 2; exp_pul = s + 1;
                end
            endcase
            if (coll) ref_err = 1;
            run_txn(kind, addr, data, s, lat, coll, cyc, pul, bus_a, bus_d);
            check($sformatf("rnd%0d_mona", i), mon_a, ref_a);
            check($sformatf("rnd%0d_mond", i), mon_d, ref_d);
            check($sformatf("rnd%0d_err", i), err, ref_err);
            check($sformatf("rnd%0d_cycles", i), cyc, exp_cyc);
            check($sformatf("rnd%0d_pulses", i), pul, exp_pul);
            if (exp_pul > 0) check($sformatf("rnd%0d_busaddr", i), bus_a, tgt);
            if (kind == 3) check($sformatf("rnd%0d_wdata", i), bus_d, data);
        end

        // Watchdog on the WAIT_TIMEOUT=4 instance: stuck write, then silent read
        reset_n = 0; step(); reset_n = 1;
        jdo = '0; jdo[17 +: 10] = 10'h010; a_s = 1;
        step();
        a_s = 0;
        jdo = '0; jdo[34:3] = 32'hDEADBEEF; b_s = 1; waitreq = 1;
        step();
        b_s = 0;
        k_wr = 0;
        for (int k = 1; k <= 4; k++) begin
            if (t_mwr && !t_ready && !t_err) k_wr++;
            step();
        end
        check("to_wr_held", k_wr, 4);
        check("to_wr_dropped", t_mwr, 0);
        check("to_wr_err", t_err, 1);
        check("to_wr_ready", t_ready, 1);
        check("to_wr_mona", t_mon_a, 10'h010);
        waitreq = 0;
        jdo = '0; jdo[17 +: 10] = 10'h011; jdo[34] = 1; a_s = 1;
        step();
        a_s = 0;
        check("to_rd_err_cleared", t_err, 0);
        check("to_rd_req", t_mrd, 1);
        step(); step(); step();
        check("to_rd_busy", t_ready, 0);
        step();
        check("to_rd_err", t_err, 1);
        check("to_rd_ready", t_ready, 1);
        check("to_rd_mond", t_mon_d, 0);
        check("to_rd_mona", t_mon_a, 10'h011);

        // Reset while a read is stalled
        reset_n = 0; step(); reset_n = 1;
        run_txn(1, 10'h055, 32'hFEEDFACE, 0, 1, 0, cyc, pul, bus_a, bus_d);
        check("rst_pre_mond", mon_d, 32'hFEEDFACE);
        na_s = 1; waitreq = 1;
        step();
        na_s = 0;
        check("rst_pre_rd", mrd, 1);
        reset_n = 0;
        step();
        reset_n = 1;
        check("rst_rd", mrd, 0);
        check("rst_mona", mon_a, 0);
        check("rst_mond", mon_d, 0);
        check("rst_ready", ready, 1);
        waitreq = 0; rdvalid = 1; rdata = 32'h5A5A5A5A;
        step();
        rdvalid = 0;
        check("rst_late_mond", mon_d, 0);
        check("rst_late_ready", ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
